// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle RV64 subset controller.
// Holds the state encoding (also exported on the debug port), the opcodes
// the controller recognises, the ALU control encodings and the
// instruction-class type that DECODE registers for later states.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_SD   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_NULL = 7'b0000000;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  typedef enum logic [1:0] {
    SRCB_RS2  = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10
  } srcb_e;

  typedef enum logic [2:0] {
    CLS_R    = 3'd0,
    CLS_I    = 3'd1,
    CLS_LD   = 3'd2,
    CLS_SD   = 3'd3,
    CLS_BEQ  = 3'd4,
    CLS_HALT = 3'd5
  } iclass_e;

endpackage

// File: rtl/opcode_classifier.sv
// Combinational opcode decode used by the controller in DECODE.
// Ports:
//   opcode  in  7  instr[6:0]
//   iclass  out    instruction class; CLS_HALT for the null and unknown opcodes
//   illegal out 1  opcode is not one the controller recognises
module opcode_classifier
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output iclass_e    iclass,
  output logic       illegal
);

  always_comb begin
    iclass  = CLS_HALT;
    illegal = 1'b0;
    case (opcode)
      OP_R:    iclass = CLS_R;
      OP_I:    iclass = CLS_I;
      OP_LD:   iclass = CLS_LD;
      OP_SD:   iclass = CLS_SD;
      OP_BEQ:  iclass = CLS_BEQ;
      OP_NULL: iclass = CLS_HALT;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multi-cycle RV64 subset datapath
// (add/sub/and/or, addi, ld, sd, beq).
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB, handshaking with a
// variable-latency unified memory via mem_ready, and halts permanently on the
// null opcode or an unknown one.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   opcode[6:0]       IR opcode field, sampled in DECODE only
//   zero              ALU zero flag, used in EXEC for beq only
//   mem_ready         current memory request completes this cycle
//   PCWrite..ALUOp    datapath strobes (combinational from state/class)
//   retire            one-cycle pulse per completed instruction
//   halted, illegal   in HALT / sticky unknown-opcode flag
//   state[2:0]        current state for debug
module multicycle_controller
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCSrc,
  output logic       IRWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IorD,
  output logic       RegWrite,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       retire,
  output logic       halted,
  output logic       illegal,
  output logic [2:0] state
);

  state_e  state_q, state_d;
  iclass_e cls_q, cls_d;
  logic    illegal_q, illegal_d;

  iclass_e dec_cls;
  logic    dec_illegal;

  opcode_classifier u_cls (
    .opcode  (opcode),
    .iclass  (dec_cls),
    .illegal (dec_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cls_q     <= CLS_R;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      illegal_q <= illegal_d;
    end
  end

  // Next state. Class is captured only in DECODE so later opcode changes
  // (the IR may be reloaded by a datapath owner) cannot disturb EXEC/MEM/WB.
  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_IDLE:   state_d = ST_FETCH;
      ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        cls_d = dec_cls;
        if (dec_cls == CLS_HALT) begin
          state_d   = ST_HALT;
          illegal_d = illegal_q | dec_illegal;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (cls_q)
          CLS_R, CLS_I:   state_d = ST_WB;
          CLS_LD, CLS_SD: state_d = ST_MEM;
          CLS_BEQ:        state_d = ST_FETCH;
          default:        state_d = ST_HALT;
        endcase
      end
      ST_MEM: if (mem_ready) state_d = (cls_q == CLS_LD) ? ST_WB : ST_FETCH;
      ST_WB:   state_d = ST_FETCH;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode. Because every output is combinational from the async-reset
  // registers, reset drops all strobes immediately, even mid-access.
  always_comb begin
    PCWrite  = 1'b0;
    PCSrc    = 1'b0;
    IRWrite  = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IorD     = 1'b0;
    RegWrite = 1'b0;
    MemtoReg = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = SRCB_RS2;
    ALUOp    = ALUOP_ADD;
    retire   = 1'b0;
    halted   = 1'b0;
    case (state_q)
      ST_FETCH: begin
        // ALU computes PC+4 while the instruction is read.
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      ST_EXEC: begin
        ALUSrcA = 1'b1;
        case (cls_q)
          CLS_R: begin
            ALUSrcB = SRCB_RS2;
            ALUOp   = ALUOP_FUNCT;
          end
          CLS_I: begin
            ALUSrcB = SRCB_IMM;
            ALUOp   = ALUOP_FUNCT;
          end
          CLS_LD, CLS_SD: begin
            ALUSrcB = SRCB_IMM;
            ALUOp   = ALUOP_ADD;
          end
          CLS_BEQ: begin
            ALUSrcB = SRCB_RS2;
            ALUOp   = ALUOP_SUB;
            PCSrc   = 1'b1;
            PCWrite = zero;
            retire  = 1'b1;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        IorD     = 1'b1;
        MemRead  = (cls_q == CLS_LD);
        MemWrite = (cls_q == CLS_SD);
        retire   = (cls_q == CLS_SD) && mem_ready;
      end
      ST_WB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
        MemtoReg = (cls_q == CLS_LD);
      end
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign illegal = illegal_q;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;
  import ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       PCWrite, PCSrc, IRWrite, MemRead, MemWrite, IorD;
  logic       RegWrite, MemtoReg, ALUSrcA, retire, halted, illegal;
  logic [1:0] ALUSrcB, ALUOp;
  logic [2:0] state;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCSrc(PCSrc), .IRWrite(IRWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .IorD(IorD), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .retire(retire),
    .halted(halted), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  // {state, PCWrite, PCSrc, IRWrite, MemRead, MemWrite, IorD, RegWrite,
  //  MemtoReg, ALUSrcA, ALUSrcB, ALUOp, retire, halted, illegal}
  logic [18:0] obs;
  assign obs = {state, PCWrite, PCSrc, IRWrite, MemRead, MemWrite, IorD, RegWrite,
                MemtoReg, ALUSrcA, ALUSrcB, ALUOp, retire, halted, illegal};

  function automatic logic [18:0] ev(input logic [2:0] st,
      input logic pcw, pcs, irw, mr, mw, iord, rw, m2r, asa,
      input logic [1:0] asb, aop, input logic ret, hlt, ill);
    return {st, pcw, pcs, irw, mr, mw, iord, rw, m2r, asa, asb, aop, ret, hlt, ill};
  endfunction

  typedef struct {
    logic        rdy;
    logic        z;
    logic [6:0]  op;
    logic [18:0] e;
  } row_t;

  logic [18:0] sb[$];
  int checks = 0;
  int failures = 0;

  // Expected output vectors, written out from the state/strobe table.
  logic [18:0] E_ZERO, E_F1, E_F0, E_DEC, E_X_R, E_X_I, E_X_LS, E_X_B1, E_X_B0;
  logic [18:0] E_M_LD, E_M_SD0, E_M_SD1, E_WB_R, E_WB_LD, E_H0, E_H1;

  initial begin
    E_ZERO  = '0;
    E_F1    = ev(3'd1, 1,0,1,1,0,0,0,0,0, 2'b10, 2'b00, 0,0,0);
    E_F0    = ev(3'd1, 0,0,0,1,0,0,0,0,0, 2'b10, 2'b00, 0,0,0);
    E_DEC   = ev(3'd2, 0,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 0,0,0);
    E_X_R   = ev(3'd3, 0,0,0,0,0,0,0,0,1, 2'b00, 2'b10, 0,0,0);
    E_X_I   = ev(3'd3, 0,0,0,0,0,0,0,0,1, 2'b01, 2'b10, 0,0,0);
    E_X_LS  = ev(3'd3, 0,0,0,0,0,0,0,0,1, 2'b01, 2'b00, 0,0,0);
    E_X_B1  = ev(3'd3, 1,1,0,0,0,0,0,0,1, 2'b00, 2'b01, 1,0,0);
    E_X_B0  = ev(3'd3, 0,1,0,0,0,0,0,0,1, 2'b00, 2'b01, 1,0,0);
    E_M_LD  = ev(3'd4, 0,0,0,1,0,1,0,0,0, 2'b00, 2'b00, 0,0,0);
    E_M_SD0 = ev(3'd4, 0,0,0,0,1,1,0,0,0, 2'b00, 2'b00, 0,0,0);
    E_M_SD1 = ev(3'd4, 0,0,0,0,1,1,0,0,0, 2'b00, 2'b00, 1,0,0);
    E_WB_R  = ev(3'd5, 0,0,0,0,0,0,1,0,0, 2'b00, 2'b00, 1,0,0);
    E_WB_LD = ev(3'd5, 0,0,0,0,0,0,1,1,0, 2'b00, 2'b00, 1,0,0);
    E_H0    = ev(3'd6, 0,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 0,1,0);
    E_H1    = ev(3'd6, 0,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 0,1,1);
  end

  // Leaves the bench 1 time unit after the edge that enters FETCH.
  task automatic do_reset();
    rst_n = 1'b0; mem_ready = 1'b0; zero = 1'b0; opcode = OP_NULL;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [18:0] e;
    rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b1; opcode = OP_R;
    #2;
    sb.push_back(E_ZERO);
    e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL reset_async got=%h exp=%h", obs, e); end
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1; mem_ready = 1'b0;
    #1;
    sb.push_back(E_ZERO);
    e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL reset_idle got=%h exp=%h", obs, e); end
    @(posedge clk); #1;
    sb.push_back(E_F0);
    e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL reset_first_fetch got=%h exp=%h", obs, e); end
  endtask

  task automatic test_add();
    row_t rows[$];
    logic [18:0] e;
    do_reset();
    // opcode corrupted after DECODE must not matter
    rows.push_back('{1'b1, 1'b0, OP_R,     E_F1});
    rows.push_back('{1'b1, 1'b0, OP_R,     E_DEC});
    rows.push_back('{1'b1, 1'b0, 7'h7f,    E_X_R});
    rows.push_back('{1'b1, 1'b0, 7'h7f,    E_WB_R});
    rows.push_back('{1'b1, 1'b0, 7'h7f,    E_F1});
    foreach (rows[i]) begin
      mem_ready = rows[i].rdy; zero = rows[i].z; opcode = rows[i].op;
      sb.push_back(rows[i].e);
      @(negedge clk);
      e = sb.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL add cyc%0d got=%h exp=%h", i, obs, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_addi_waits();
    row_t rows[$];
    logic [18:0] e;
    do_reset();
    rows.push_back('{1'b0, 1'b0, OP_I, E_F0});
    rows.push_back('{1'b1, 1'b0, OP_I, E_F1});
    rows.push_back('{1'b0, 1'b1, OP_I, E_DEC});
    rows.push_back('{1'b0, 1'b1, OP_I, E_X_I});
    rows.push_back('{1'b0, 1'b0, OP_I, E_WB_R});
    rows.push_back('{1'b0, 1'b0, OP_I, E_F0});
    foreach (rows[i]) begin
      mem_ready = rows[i].rdy; zero = rows[i].z; opcode = rows[i].op;
      sb.push_back(rows[i].e);
      @(negedge clk);
      e = sb.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL addi cyc%0d got=%h exp=%h", i, obs, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ld();
    row_t rows[$];
    logic [18:0] e;
    do_reset();
    rows.push_back('{1'b1, 1'b0, OP_LD, E_F1});
    rows.push_back('{1'b1, 1'b0, OP_LD, E_DEC});
    rows.push_back('{1'b1, 1'b0, OP_LD, E_X_LS});
    rows.push_back('{1'b0, 1'b0, OP_LD, E_M_LD});
    rows.push_back('{1'b0, 1'b0, OP_LD, E_M_LD});
    rows.push_back('{1'b1, 1'b0, OP_LD, E_M_LD});
    rows.push_back('{1'b1, 1'b0, OP_LD, E_WB_LD});
    rows.push_back('{1'b0, 1'b0, OP_LD, E_F0});
    foreach (rows[i]) begin
      mem_ready = rows[i].rdy; zero = rows[i].z; opcode = rows[i].op;
      sb.push_back(rows[i].e);
      @(negedge clk);
      e = sb.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL ld cyc%0d got=%h exp=%h", i, obs, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sd();
    row_t rows[$];
    logic [18:0] e;
    do_reset();
    rows.push_back('{1'b1, 1'b0, OP_SD, E_F1});
    rows.push_back('{1'b1, 1'b0, OP_SD, E_DEC});
    rows.push_back('{1'b1, 1'b0, OP_SD, E_X_LS});
    rows.push_back('{1'b0, 1'b0, OP_SD, E_M_SD0});
    rows.push_back('{1'b1, 1'b0, OP_SD, E_M_SD1});
    rows.push_back('{1'b1, 1'b0, OP_SD, E_F1});
    foreach (rows[i]) begin
      mem_ready = rows[i].rdy; zero = rows[i].z; opcode = rows[i].op;
      sb.push_back(rows[i].e);
      @(negedge clk);
      e = sb.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL sd cyc%0d got=%h exp=%h", i, obs, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sd_reset_mid_mem();
    row_t rows[$];
    logic [18:0] e;
    do_reset();
    rows.push_back('{1'b1, 1'b0, OP_SD, E_F1});
    rows.push_back('{1'b1, 1'b0, OP_SD, E_DEC});
    rows.push_back('{1'b1, 1'b0, OP_SD, E_X_LS});
    rows.push_back('{1'b0, 1'b0, OP_SD, E_M_SD0});
    foreach (rows[i]) begin
      mem_ready = rows[i].rdy; zero = rows[i].z; opcode = rows[i].op;
      sb.push_back(rows[i].e);
      @(negedge clk);
      e = sb.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL sdrst cyc%0d got=%h exp=%h", i, obs, e); end
      if (i < rows.size() - 1) begin @(posedge clk); #1; end
    end
    // Still in MEM with MemWrite high; pull reset mid-cycle.
    #2 rst_n = 1'b0;
    #1;
    sb.push_back(E_ZERO);
    e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL sdrst_drop got=%h exp=%h", obs, e); end
    mem_ready = 1'b1;
    @(posedge clk); #1;
    sb.push_back(E_ZERO);
    e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL sdrst_hold got=%h exp=%h", obs, e); end
    @(negedge clk);
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    sb.push_back(E_F0);
    e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL sdrst_refetch got=%h exp=%h", obs, e); end
  endtask

  task automatic test_beq_back_to_back();
    row_t rows[$];
    logic [18:0] e;
    do_reset();
    rows.push_back('{1'b1, 1'b0, OP_BEQ, E_F1});
    rows.push_back('{1'b1, 1'b0, OP_BEQ, E_DEC});
    rows.push_back('{1'b1, 1'b1, OP_BEQ, E_X_B1});
    rows.push_back('{1'b1, 1'b1, OP_BEQ, E_F1});
    rows.push_back('{1'b0, 1'b1, OP_BEQ, E_DEC});
    rows.push_back('{1'b0, 1'b0, OP_BEQ, E_X_B0});
    rows.push_back('{1'b1, 1'b0, OP_BEQ, E_F1});
    foreach (rows[i]) begin
      mem_ready = rows[i].rdy; zero = rows[i].z; opcode = rows[i].op;
      sb.push_back(rows[i].e);
      @(negedge clk);
      e = sb.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL beq cyc%0d got=%h exp=%h", i, obs, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_halt(input logic [6:0] op, input logic [18:0] eh, input string nm);
    row_t rows[$];
    logic [18:0] e;
    do_reset();
    rows.push_back('{1'b1, 1'b0, op, E_F1});
    rows.push_back('{1'b1, 1'b0, op, E_DEC});
    for (int k = 0; k < 11; k++)
      rows.push_back('{logic'(k[0]), logic'(k[1]), (k > 2) ? OP_R : op, eh});
    foreach (rows[i]) begin
      mem_ready = rows[i].rdy; zero = rows[i].z; opcode = rows[i].op;
      sb.push_back(rows[i].e);
      @(negedge clk);
      e = sb.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL %s cyc%0d got=%h exp=%h", nm, i, obs, e); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; mem_ready = 1'b0; zero = 1'b0; opcode = OP_NULL;
    #1;
    test_reset();
    test_add();
    test_addi_waits();
    test_ld();
    test_sd();
    test_sd_reset_mid_mem();
    test_beq_back_to_back();
    test_halt(OP_NULL, E_H0, "halt_null");
    test_halt(7'h7f, E_H1, "halt_illegal");
    test_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
